// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: truth-table sweep sequencer for a 3-input combinational unit.
// It drives abc = 000..111 in ascending order and holds each vector for
// SETTLE_CYCLES cycles. One cycle later it samples y and builds an 8-bit table.
// It then compares the table with the expected pattern latched at start.
module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_expected,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_table,
  output logic       o_pass,
  output logic [3:0] o_err_cnt,
  output logic [2:0] o_err_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last counter value in SETTLE. The count starts at 0, so this value ends
  // the SETTLE_CYCLES-long hold.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [7:0] exp_q;
  logic [7:0] exp_nxt;
  logic [7:0] table_nxt;
  logic       pass_nxt;
  logic [3:0] err_cnt_nxt;
  logic [2:0] err_idx_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       mismatch;

  // The unit inputs come straight from the vector index register.
  // DONE and IDLE drive 000 because idx returns to 0 when the sweep ends.
  assign o_a = idx[2];
  assign o_b = idx[1];
  assign o_c = idx[0];

  // The sampled y disagrees with the expected bit for the current vector.
  assign mismatch = (i_y != exp_q[idx]);

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values and simulation order cannot matter.
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed ascending sweep; no wrap after vector 7.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first. Without it, a path that skips the assignment infers a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = SETTLE;
      SETTLE:  if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 3'd7) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic: next values for every registered output.
  always_comb begin
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    exp_nxt     = exp_q;
    table_nxt   = o_table;
    pass_nxt    = o_pass;
    err_cnt_nxt = o_err_cnt;
    err_idx_nxt = o_err_idx;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          // Only this latched copy of the expected pattern is used later.
          exp_nxt     = i_expected;
          table_nxt   = 8'h00;
          pass_nxt    = 1'b0;
          err_cnt_nxt = 4'd0;
          err_idx_nxt = 3'd0;
          idx_nxt     = 3'd0;
          cnt_nxt     = 4'd0;
          busy_nxt    = 1'b1;
        end
      end
      SETTLE: begin
        cnt_nxt  = cnt + 4'd1;
        busy_nxt = 1'b1;
      end
      SAMPLE: begin
        table_nxt[idx] = i_y;
        if (mismatch) begin
          err_cnt_nxt = o_err_cnt + 4'd1;
          if (o_err_cnt == 4'd0) err_idx_nxt = idx;
        end
        if (idx == 3'd7) begin
          // The sweep ends here. The index parks at 0 so the unit sees 000.
          idx_nxt  = 3'd0;
          done_nxt = 1'b1;
          pass_nxt = (err_cnt_nxt == 4'd0);
        end else begin
          idx_nxt  = idx + 3'd1;
          cnt_nxt  = 4'd0;
          busy_nxt = 1'b1;
        end
      end
      DONE: begin
        // Results hold until the next accepted start.
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    // NOTE: the reset clears every register, including the latched expected
    // pattern, so a reset mid-sweep leaves no trace of the aborted run.
    if (!i_rst_n) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      exp_q     <= 8'h00;
      o_table   <= 8'h00;
      o_pass    <= 1'b0;
      o_err_cnt <= 4'd0;
      o_err_idx <= 3'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      exp_q     <= exp_nxt;
      o_table   <= table_nxt;
      o_pass    <= pass_nxt;
      o_err_cnt <= err_cnt_nxt;
      o_err_idx <= err_idx_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
    end
  end

endmodule
